mem_port_arbiter: RTL and testbench

//   Shares one memory port between instruction fetch (I) and load/store (D) of the core.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-port signals of the shared memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_size;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_size;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, m_ack, m_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_size
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, m_ack, m_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, round-robin on ties, sticky timeout error.
module mem_port_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic              owner_d;
    logic              last_d;
    logic [CW-1:0]     cnt;
    logic              pick_d;
    logic              timeout;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] resp_data;

    // last_d starts at 0 (fetch), so the first tie after reset goes to load/store
    assign pick_d    = bus.d_req && (!bus.i_req || !last_d);
    assign pick_addr = pick_d ? bus.d_addr : bus.i_addr;
    assign timeout   = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 1);
    assign resp_data = (bus.m_ack && !bus.m_we) ? bus.m_rdata : '0;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            last_d      <= 1'b0;
            cnt         <= '0;
            err         <= 1'b0;
            bus.i_gnt   <= 1'b0;
            bus.i_valid <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_gnt   <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.d_rdata <= '0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_size  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_req || bus.d_req) begin
                    state       <= BUSY;
                    owner_d     <= pick_d;
                    last_d      <= pick_d;
                    cnt         <= '0;
                    bus.i_gnt   <= !pick_d;
                    bus.d_gnt   <= pick_d;
                    bus.m_req   <= 1'b1;
                    bus.m_we    <= pick_d && bus.d_we;
                    bus.m_addr  <= pick_addr;
                    bus.m_wdata <= pick_d ? bus.d_wdata : '0;
                    bus.m_size  <= pick_d ? bus.d_size : 3'b010;
                end
                BUSY: begin
                    bus.i_gnt <= 1'b0;
                    bus.d_gnt <= 1'b0;
                    // an acknowledge in the timeout cycle completes normally
                    if (bus.m_ack || timeout) begin
                        state       <= RESP;
                        bus.m_req   <= 1'b0;
                        err         <= err || !bus.m_ack;
                        bus.i_valid <= !owner_d;
                        bus.d_valid <= owner_d;
                        bus.i_rdata <= owner_d ? '0 : resp_data;
                        bus.d_rdata <= owner_d ? resp_data : '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    bus.i_valid <= 1'b0;
                    bus.d_valid <= 1'b0;
                    bus.i_rdata <= '0;
                    bus.d_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, err, t_busy, t_err;
  int checks = 0;
  int errors = 0;
  bit last_d = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter_if tbus ();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave), .busy(busy), .err(err));
  mem_port_arbiter #(.TIMEOUT(4)) dut_t (.clk(clk), .reset(reset), .bus(tbus.slave), .busy(t_busy), .err(t_err));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_size = '0; bus.m_ack = 0; bus.m_rdata = '0;
    tbus.i_req = 0; tbus.i_addr = '0; tbus.d_req = 0; tbus.d_we = 0; tbus.d_addr = '0;
    tbus.d_wdata = '0; tbus.d_size = '0; tbus.m_ack = 0; tbus.m_rdata = '0;
  endtask
  task automatic run_txn(input bit ir, input bit dr, input bit we, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd, input logic [2:0] sz,
                         input int k, input logic [31:0] rd);
    bit win_d;
    logic [31:0] exp_addr, exp_data;
    win_d = dr && (!ir || !last_d);
    last_d = win_d;
    exp_addr = win_d ? da : ia;
    exp_data = (win_d && we) ? 32'h0 : rd;
    bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_we = we;
    bus.d_addr = da; bus.d_wdata = wd; bus.d_size = sz;
    tick;
    bus.i_req = 0; bus.d_req = 0;
    for (int c = 1; c <= k; c++) begin
      chk("m_req", bus.m_req, 1'b1);
      chk("m_addr", bus.m_addr, exp_addr);
      chk("m_we", bus.m_we, win_d && we);
      if (win_d) begin
        chk("m_wdata", bus.m_wdata, wd);
        chk("m_size", bus.m_size, sz);
      end
      chk("i_gnt", bus.i_gnt, (c == 1) && !win_d);
      chk("d_gnt", bus.d_gnt, (c == 1) && win_d);
      chk("i_valid_busy", bus.i_valid, 1'b0);
      chk("busy", busy, 1'b1);
      bus.m_rdata = (c == k) ? rd : $urandom;
      bus.m_ack = (c == k);
      tick;
    end
    bus.m_ack = 0;
    chk("i_valid", bus.i_valid, !win_d);
    chk("d_valid", bus.d_valid, win_d);
    chk("i_rdata", bus.i_rdata, win_d ? 32'h0 : exp_data);
    chk("d_rdata", bus.d_rdata, win_d ? exp_data : 32'h0);
    chk("m_req_resp", bus.m_req, 1'b0);
    chk("busy_resp", busy, 1'b1);
    tick;
    chk("valid_clear", bus.i_valid | bus.d_valid, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("err_main", err, 1'b0);
  endtask
  task automatic t_load(input int ack_at, input logic [31:0] rd, input bit exp_err);
    int n;
    n = (ack_at != 0) ? ack_at : 4;
    tbus.d_req = 1; tbus.d_we = 0; tbus.d_addr = $urandom;
    tick;
    tbus.d_req = 0;
    for (int c = 1; c <= n; c++) begin
      chk("t_m_req", tbus.m_req, 1'b1);
      tbus.m_ack = (c == ack_at);
      tbus.m_rdata = rd;
      tick;
    end
    tbus.m_ack = 0;
    chk("t_m_req_drop", tbus.m_req, 1'b0);
    chk("t_d_valid", tbus.d_valid, 1'b1);
    chk("t_d_rdata", tbus.d_rdata, (ack_at != 0) ? rd : 32'h0);
    chk("t_err", t_err, exp_err);
    tick;
    chk("t_valid_clear", tbus.d_valid, 1'b0);
  endtask
  initial begin
    idle_inputs;
    tick;
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_gnt", bus.i_gnt | bus.d_gnt, 1'b0);
    reset = 1;
    tick;
    run_txn(1, 0, 0, 32'h0, 32'h0, 32'h0, 3'b010, 3, 32'h0050_0093);
    reset = 0; last_d = 0;
    tick;
    reset = 1;
    tick;
    run_txn(1, 1, 0, 32'h4, 32'h100, 32'h0, 3'b010, 1, 32'h1111_0000);
    run_txn(1, 1, 0, 32'h4, 32'h100, 32'h0, 3'b010, 1, 32'h2222_0000);
    run_txn(1, 1, 0, 32'h8, 32'h104, 32'h0, 3'b010, 1, 32'h3333_0000);
    run_txn(0, 1, 1, 32'h0, 32'h2000, 32'hDEAD_BEEF, 3'b010, 5, 32'hFFFF_FFFF);
    bus.m_ack = 1; bus.m_rdata = 32'hABCD_1234;
    tick;
    bus.m_ack = 0;
    chk("idle_ack_valid", bus.i_valid | bus.d_valid, 1'b0);
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_err", err, 1'b0);
    tick;
    chk("idle_ack_valid2", bus.i_valid | bus.d_valid, 1'b0);
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 3'b010, 2, 32'h0000_0013);
    bus.i_req = 1; bus.i_addr = 32'h80;
    tick;
    bus.i_req = 0;
    tick;
    chk("pre_rst_m_req", bus.m_req, 1'b1);
    #2 reset = 0;
    #1;
    chk("async_m_req", bus.m_req, 1'b0);
    chk("async_busy", busy, 1'b0);
    last_d = 0;
    tick;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      bus.m_ack = (i == 0);
      tick;
      chk("post_rst_valid", bus.i_valid | bus.d_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    bus.m_ack = 0;
    for (int n = 0; n < 40; n++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1;
      run_txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              3'($urandom_range(0, 7)), int'($urandom_range(1, 6)), $urandom);
    end
    t_load(4, 32'h1234_5678, 1'b0);
    t_load(0, 32'h5555_AAAA, 1'b1);
    t_load(2, 32'h0BAD_F00D, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
